// File: rtl/nark_rf_pkg.sv
// Shared sizing and types for the one-hot-addressed register file.
package nark_rf_pkg;

   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned ADDR_W   = 3;

   typedef logic [NUM_REGS-1:0] rf_onehot_t;
   typedef logic [ADDR_W-1:0]   rf_addr_t;

endpackage : nark_rf_pkg

// File: rtl/onehot_validator.sv
// Classifies a write-enable vector as empty, legal (exactly one hot) or illegal,
// and encodes the hot bit's index for the legal case.
module onehot_validator
   import nark_rf_pkg::*;
(
   input  logic [NUM_REGS-1:0] onehot,
   output logic                is_zero,
   output logic                is_legal,
   output logic [ADDR_W-1:0]   idx
);

   // OR-encoder: only meaningful when is_legal is set.
   always_comb begin
      idx = '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (onehot[i]) begin
            idx = idx | rf_addr_t'(i);
         end
      end
   end

   assign is_zero  = (onehot == '0);
   assign is_legal = $onehot(onehot);

endmodule : onehot_validator

// File: rtl/onehot_regfile_8x.sv
// 8-entry register file written by a one-hot enable vector; two registered read
// ports with write bypass, a busy scoreboard and a sticky multi-hot error flag.
module onehot_regfile_8x
   import nark_rf_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic                CLK,
   input  logic                RESET_N,
   input  logic [NUM_REGS-1:0] WR_EN_ONEHOT,
   input  logic [DATA_W-1:0]   WR_DATA,
   input  logic [ADDR_W-1:0]   RD_ADDR_A,
   input  logic [ADDR_W-1:0]   RD_ADDR_B,
   output logic [DATA_W-1:0]   RD_DATA_A,
   output logic [DATA_W-1:0]   RD_DATA_B,
   input  logic                RESERVE_VALID,
   input  logic [ADDR_W-1:0]   RESERVE_ADDR,
   output logic [NUM_REGS-1:0] BUSY,
   input  logic                CLEAR_ERROR,
   output logic                WR_ERROR
);

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic                wr_zero;
   logic                wr_legal;
   logic [ADDR_W-1:0]   wr_idx;
   logic                wr_illegal;
   logic [NUM_REGS-1:0] busy_nxt;
   logic [DATA_W-1:0]   rd_a_nxt;
   logic [DATA_W-1:0]   rd_b_nxt;
   logic                err_nxt;

   onehot_validator u_validator (
      .onehot   (WR_EN_ONEHOT),
      .is_zero  (wr_zero),
      .is_legal (wr_legal),
      .idx      (wr_idx)
   );

   assign wr_illegal = !wr_zero && !wr_legal;

   // Read muxes with same-cycle bypass of a legal write.
   always_comb begin
      rd_a_nxt = regs[RD_ADDR_A];
      rd_b_nxt = regs[RD_ADDR_B];
      if (wr_legal && (wr_idx == RD_ADDR_A)) begin
         rd_a_nxt = WR_DATA;
      end
      if (wr_legal && (wr_idx == RD_ADDR_B)) begin
         rd_b_nxt = WR_DATA;
      end
   end

   // Scoreboard: a new reservation outranks a completing write-back.
   always_comb begin
      busy_nxt = BUSY;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
         if (RESERVE_VALID && (RESERVE_ADDR == rf_addr_t'(i))) begin
            busy_nxt[i] = 1'b1;
         end else if (wr_legal && WR_EN_ONEHOT[i]) begin
            busy_nxt[i] = 1'b0;
         end
      end
   end

   always_comb begin
      err_nxt = WR_ERROR;
      if (wr_illegal) begin
         err_nxt = 1'b1;
      end else if (CLEAR_ERROR) begin
         err_nxt = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i] <= '0;
         end
         RD_DATA_A <= '0;
         RD_DATA_B <= '0;
         BUSY      <= '0;
         WR_ERROR  <= 1'b0;
      end else begin
         if (wr_legal) begin
            regs[wr_idx] <= WR_DATA;
         end
         RD_DATA_A <= rd_a_nxt;
         RD_DATA_B <= rd_b_nxt;
         BUSY      <= busy_nxt;
         WR_ERROR  <= err_nxt;
      end
   end

endmodule : onehot_regfile_8x
